// File: rtl/delta_stress_monitor_if.sv
// delta_stress_monitor_if: sample strobe and word in, plateau report out; DELTA_STRESS_DELTA_OUT_EN adds delta
interface delta_stress_monitor_if #(parameter int WIDTH = 6);
  logic sample_valid;
  logic [WIDTH-1:0] hart;
  logic stable_puls;
  logic [WIDTH-1:0] stable_value;
  logic gedaald;
  logic error;
`ifdef DELTA_STRESS_DELTA_OUT_EN
  logic signed [WIDTH:0] delta;
  modport master(output sample_valid, hart, input stable_puls, stable_value, gedaald, error, delta);
  modport slave(input sample_valid, hart, output stable_puls, stable_value, gedaald, error, delta);
`else
  modport master(output sample_valid, hart, input stable_puls, stable_value, gedaald, error);
  modport slave(input sample_valid, hart, output stable_puls, stable_value, gedaald, error);
`endif
endinterface

// File: rtl/delta_stress_monitor.sv
// delta_stress_monitor: heart-rate plateau detector with tolerance and hold-off; DELTA_STRESS_DELTA_OUT_EN adds signed delta output
module delta_stress_monitor #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int TOL = 0,
  parameter int HOLDOFF = 7
) (
  input logic slow,
  input logic reset,
  delta_stress_monitor_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int HW = HOLDOFF > 0 ? $clog2(HOLDOFF + 1) : 1;
  typedef enum logic [1:0] {S_EMPTY, S_RUN, S_STABLE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] run_ref, ref_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [HW-1:0] hold, hold_n;
  logic [WIDTH:0] diff;
  logic in_tol, report;
  assign diff = bus.hart >= run_ref ? {1'b0, bus.hart} - {1'b0, run_ref} : {1'b0, run_ref} - {1'b0, bus.hart};
  assign in_tol = diff <= (WIDTH + 1)'(TOL);
  always_comb begin
    state_n = state;
    ref_n = run_ref;
    cnt_n = cnt;
    hold_n = hold;
    report = 1'b0;
    if (bus.sample_valid) begin
      hold_n = hold == '0 ? hold : hold - HW'(1);
      if (state == S_EMPTY || !in_tol) begin
        state_n = S_RUN;
        ref_n = bus.hart;
        cnt_n = CW'(1);
      end else if (state == S_RUN) begin
        cnt_n = cnt == CW'(DEPTH) ? cnt : cnt + CW'(1);
        report = cnt_n == CW'(DEPTH) && hold_n == '0;
        state_n = report ? S_STABLE : S_RUN;
        hold_n = report ? HW'(HOLDOFF) : hold_n;
      end
    end
  end
  always_ff @(posedge slow) begin
    if (!reset) begin
      state <= S_EMPTY;
      run_ref <= '0;
      cnt <= '0;
      hold <= '0;
      bus.stable_puls <= 1'b0;
      bus.stable_value <= '1;
      bus.gedaald <= 1'b0;
      bus.error <= 1'b0;
    end else begin
      state <= state_n;
      run_ref <= ref_n;
      cnt <= cnt_n;
      hold <= hold_n;
      bus.stable_puls <= report;
      if (report) begin
        bus.stable_value <= run_ref;
        bus.gedaald <= run_ref > bus.stable_value;
        bus.error <= run_ref < bus.stable_value;
      end
    end
  end
`ifdef DELTA_STRESS_DELTA_OUT_EN
  always_ff @(posedge slow) begin
    if (!reset) bus.delta <= '0;
    else if (report) bus.delta <= $signed({1'b0, run_ref}) - $signed({1'b0, bus.stable_value});
  end
`endif
endmodule

// File: tb/tb_delta_stress_monitor.sv
// tb_delta_stress_monitor: vector table, hand sequences and randomized run against a plateau reference model
module tb_delta_stress_monitor;
  localparam int DEPTH = 4;
  localparam int HOLD = 7;
  logic slow = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 slow = ~slow;
  delta_stress_monitor_if #(.WIDTH(6)) ia();
  delta_stress_monitor_if #(.WIDTH(6)) ib();
  delta_stress_monitor da(.slow(slow), .reset(reset), .bus(ia));
  delta_stress_monitor #(.TOL(1)) db(.slow(slow), .reset(reset), .bus(ib));
  typedef struct {
    logic rstn;
    logic v;
    logic [5:0] h;
    logic p;
    logic [5:0] val;
    logic g;
    logic e;
  } vec_t;
  vec_t tbl[$];
  int m_have[2], m_ref[2], m_len[2], m_rep[2], m_since[2], m_last[2];
  int m_p[2], m_g[2], m_e[2], m_d[2];
  function automatic void add(int n, logic r, logic v, logic [5:0] h, logic p, logic [5:0] val, logic g, logic e);
    for (int i = 0; i < n; i++) tbl.push_back('{r, v, h, p, val, g, e});
  endfunction
  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  task automatic model(int k, int tol, logic rstn, logic v, logic [5:0] h);
    int d;
    if (!rstn) begin
      m_have[k] = 0; m_since[k] = HOLD; m_last[k] = 63;
      m_p[k] = 0; m_g[k] = 0; m_e[k] = 0; m_d[k] = 0;
    end else begin
      m_p[k] = 0;
      if (v) begin
        if (m_since[k] < 1000) m_since[k]++;
        d = int'(h) - m_ref[k];
        if (d < 0) d = -d;
        if (m_have[k] == 0 || d > tol) begin
          m_have[k] = 1; m_ref[k] = int'(h); m_len[k] = 1; m_rep[k] = 0;
        end else m_len[k]++;
        if (m_rep[k] == 0 && m_len[k] >= DEPTH && m_since[k] >= HOLD) begin
          m_p[k] = 1;
          m_g[k] = m_ref[k] > m_last[k] ? 1 : 0;
          m_e[k] = m_ref[k] < m_last[k] ? 1 : 0;
          m_d[k] = m_ref[k] - m_last[k];
          m_last[k] = m_ref[k];
          m_since[k] = 0;
          m_rep[k] = 1;
        end
      end
    end
  endtask
  task automatic step(logic rstn, logic v, logic [5:0] h);
    reset = rstn;
    ia.sample_valid = v; ia.hart = h;
    ib.sample_valid = v; ib.hart = h;
    @(posedge slow);
    #1;
    model(0, 0, rstn, v, h);
    model(1, 1, rstn, v, h);
  endtask
  task automatic check_models();
    check("a_puls", int'(ia.stable_puls), m_p[0]);
    check("a_value", int'(ia.stable_value), m_last[0]);
    check("a_gedaald", int'(ia.gedaald), m_g[0]);
    check("a_error", int'(ia.error), m_e[0]);
    check("b_puls", int'(ib.stable_puls), m_p[1]);
    check("b_value", int'(ib.stable_value), m_last[1]);
    check("b_gedaald", int'(ib.gedaald), m_g[1]);
    check("b_error", int'(ib.error), m_e[1]);
`ifdef DELTA_STRESS_DELTA_OUT_EN
    check("a_delta", int'(ia.delta), m_d[0]);
    check("b_delta", int'(ib.delta), m_d[1]);
`endif
  endtask
  task automatic check_b(string name, int p, int val, int g, int e);
    check({name, "_puls"}, int'(ib.stable_puls), p);
    check({name, "_value"}, int'(ib.stable_value), val);
    check({name, "_gedaald"}, int'(ib.gedaald), g);
    check({name, "_error"}, int'(ib.error), e);
  endtask
  initial begin
    int base;
    logic [5:0] h;
    ia.sample_valid = 1'b0; ia.hart = '0;
    ib.sample_valid = 1'b0; ib.hart = '0;
    for (int k = 0; k < 2; k++) begin
      m_have[k] = 0; m_ref[k] = 0; m_len[k] = 0; m_rep[k] = 0; m_since[k] = HOLD;
      m_last[k] = 63; m_p[k] = 0; m_g[k] = 0; m_e[k] = 0; m_d[k] = 0;
    end
    add(1, 0, 0, 0, 0, 63, 0, 0);
    add(3, 1, 1, 30, 0, 63, 0, 0);
    add(1, 1, 1, 30, 1, 30, 0, 1);
    add(6, 1, 1, 40, 0, 30, 0, 1);
    add(1, 1, 1, 40, 1, 40, 1, 0);
    add(1, 1, 1, 40, 0, 40, 1, 0);
    add(1, 0, 0, 0, 0, 63, 0, 0);
    add(3, 1, 1, 50, 0, 63, 0, 0);
    add(1, 1, 1, 50, 1, 50, 0, 1);
    add(1, 0, 0, 0, 0, 63, 0, 0);
    add(2, 1, 1, 30, 0, 63, 0, 0);
    add(1, 1, 1, 31, 0, 63, 0, 0);
    add(3, 1, 1, 30, 0, 63, 0, 0);
    add(1, 1, 1, 30, 1, 30, 0, 1);
    for (int i = 0; i < 7; i++) add(1, 1, 1, (i % 2) != 0 ? 6'd20 : 6'd10, 0, 30, 0, 1);
    add(3, 1, 1, 30, 0, 30, 0, 1);
    add(1, 1, 1, 30, 1, 30, 0, 0);
    add(1, 0, 0, 0, 0, 63, 0, 0);
    for (int i = 0; i < 4; i++) begin
      add(1, 1, 1, 25, i == 3 ? 1'b1 : 1'b0, i == 3 ? 6'd25 : 6'd63, 0, i == 3 ? 1'b1 : 1'b0);
      add(3, 1, 0, 25, 0, i == 3 ? 6'd25 : 6'd63, 0, i == 3 ? 1'b1 : 1'b0);
    end
    add(1, 0, 0, 0, 0, 63, 0, 0);
    add(3, 1, 1, 30, 0, 63, 0, 0);
    add(1, 0, 1, 30, 0, 63, 0, 0);
    add(3, 1, 1, 30, 0, 63, 0, 0);
    add(1, 1, 1, 30, 1, 30, 0, 1);
    add(1, 0, 0, 0, 0, 63, 0, 0);
    add(3, 1, 1, 63, 0, 63, 0, 0);
    add(1, 1, 1, 63, 1, 63, 0, 0);
    add(2, 1, 1, 63, 0, 63, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rstn, tbl[i].v, tbl[i].h);
      check($sformatf("vec%0d_puls", i), int'(ia.stable_puls), int'(tbl[i].p));
      check($sformatf("vec%0d_value", i), int'(ia.stable_value), int'(tbl[i].val));
      check($sformatf("vec%0d_gedaald", i), int'(ia.gedaald), int'(tbl[i].g));
      check($sformatf("vec%0d_error", i), int'(ia.error), int'(tbl[i].e));
      check_models();
    end
    step(0, 0, 0);
    check_b("tol_reset", 0, 63, 0, 0);
    step(1, 1, 20); check_b("tol_s1", 0, 63, 0, 0);
    step(1, 1, 21); check_b("tol_s2", 0, 63, 0, 0);
    step(1, 1, 19); check_b("tol_s3", 0, 63, 0, 0);
    step(1, 1, 20); check_b("tol_s4", 1, 20, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 22);
      check_b($sformatf("tol_restart%0d", i), 0, 20, 0, 1);
    end
    step(1, 1, 22); check_b("tol_deferred", 1, 22, 1, 0);
    step(1, 1, 22); check_b("tol_after", 0, 22, 1, 0);
    step(0, 0, 0);
    base = 30;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 40) == 0) base = int'($urandom_range(0, 63));
      h = 6'(base + int'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0) h = 6'($urandom_range(0, 63));
      step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, h);
      check_models();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/delta_stress_monitor.md
Name: delta_stress_monitor

Overview:
- Parametrised successor to the single-channel heart-rate stability detector in the stress path.
- Watches a sampled heart-rate word and declares a plateau after DEPTH consecutive samples within TOL of the run's first sample.
- On each plateau, latches the plateau value and reports its direction versus the previous plateau.
- Adds a sample strobe, a tolerance window and a sample-based hold-off between reports; sits between the heart-rate sampler and the stress/feedback logic.

Parameters:
- WIDTH, 6, heart-rate word width in bits (>=2).
- DEPTH, 4, consecutive in-tolerance samples needed to declare a plateau (>=2).
- TOL, 0, maximum absolute difference from the run reference still counted as equal.
- HOLDOFF, 7, minimum number of valid samples after a report before the next report may fire (>=0).

Ports:
- slow  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- sample_valid  input  1  hart is sampled on this cycle.
- hart  input  WIDTH  heart-rate sample, unsigned.
- stable_puls  output  1  one-cycle pulse on each plateau report.
- stable_value  output  WIDTH  last reported plateau value.
- gedaald  output  1  last report: new plateau > previous plateau.
- error  output  1  last report: new plateau < previous plateau.

Behaviour:
- Reset (reset==0 at a slow edge): state=S_EMPTY, run count=0, run ref=0, hold-off count=0, stable_puls=0, stable_value=all ones (2^WIDTH-1), gedaald=0, error=0.
- All outputs are registered. Nothing changes on cycles with sample_valid=0, except that stable_puls returns to 0.
- In-tolerance test: |hart - ref| <= TOL, computed in WIDTH+1 bits with no wrap.
- S_EMPTY, valid sample: ref<=hart, cnt<=1, go to S_RUN.
- S_RUN, valid sample in tolerance: cnt<=min(cnt+1, DEPTH).
- S_RUN, valid sample out of tolerance: ref<=hart, cnt<=1 (the new run starts from this sample).
- Report condition: in S_RUN, on a valid in-tolerance sample where the updated cnt==DEPTH and the updated hold-off count==0.
  - Next cycle: stable_puls=1, stable_value<=ref, gedaald<=(ref > old stable_value), error<=(ref < old stable_value).
  - State goes to S_STABLE; hold-off count is loaded with HOLDOFF.
- Deferred report: if cnt reaches DEPTH while hold-off is still nonzero, stay in S_RUN with cnt saturated at DEPTH. Report on the first later valid in-tolerance sample at which hold-off reaches 0.
- S_STABLE, valid in-tolerance sample: stay; no further pulse.
- S_STABLE, valid out-of-tolerance sample: ref<=hart, cnt<=1, go to S_RUN.
- Hold-off count decrements by 1 per valid sample, saturating at 0. On the report cycle it is loaded with HOLDOFF, not decremented.
- Equal plateau value (ref == old stable_value): pulse still fires with gedaald=0 and error=0.
- First report after reset compares against all ones. A plateau at 2^WIDTH-1 therefore gives gedaald=0 and error=0.
- gedaald and error hold until the next report; they are never both 1.
- Reset asserted mid-run or mid-pulse: all state returns to the reset values at that edge; a pending deferred report is discarded.

Optional Feature:
- Macro: DELTA_STRESS_DELTA_OUT_EN.
- Defined: adds output delta, signed WIDTH+1 bits, loaded on each report with ref - old stable_value. Reset value is 0; it holds between reports.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Defaults; release reset; 4 valid samples of 30 -> stable_puls high exactly 1 cycle after the 4th; stable_value=30, error=1, gedaald=0.
- Continue from the first test with 8 valid samples of 40 -> no pulse on the 4th (hold-off=3). Pulse after the 7th sample (hold-off reaches 0); stable_value=40, gedaald=1, error=0; no pulse on the 8th.
- TOL=1; samples 20,21,19,20 -> pulse after the 4th, stable_value=20. Then 22 -> run restarts (|22-20|=2), state S_RUN.
- Defaults; samples 30,30,31,30,30,30,30 -> run restarts at 31 and again at 30. Pulse only after the 7th sample, value 30.
- Defaults; 4 samples of 25, each separated by 3 cycles of sample_valid=0 -> single pulse after the 4th valid sample; invalid cycles leave cnt unchanged.
- Assert reset with cnt=3 -> next edge: stable_value=63, gedaald=0, error=0, stable_puls=0. With DELTA_STRESS_DELTA_OUT_EN defined, the first test gives delta=-33.
